// File: rtl/i2c_pad_arbiter.sv
// Shares one open-drain SCL/SDA pad pair between two I2C master cores, tracking bus-busy
// from START/STOP. Define I2C_ARB_TIMEOUT_EN to add the stuck-bus forced-release counter.
module i2c_pad_arbiter #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic CLK_I,
    input  logic RESET,
    input  logic REQ_A,
    input  logic REQ_B,
    output logic GNT_A,
    output logic GNT_B,
    input  logic A_SCL_PAD_O,
    input  logic A_SCL_PADOEN_O,
    input  logic A_SDA_PAD_O,
    input  logic A_SDA_PADOEN_O,
    input  logic B_SCL_PAD_O,
    input  logic B_SCL_PADOEN_O,
    input  logic B_SDA_PAD_O,
    input  logic B_SDA_PADOEN_O,
    input  logic SCL_PAD_I,
    input  logic SDA_PAD_I,
    output logic SCL_PAD_O,
    output logic SCL_PADOEN_O,
    output logic SDA_PAD_O,
    output logic SDA_PADOEN_O,
    output logic BUS_BUSY,
    output logic START_DET,
    output logic STOP_DET,
    output logic TIMEOUT
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    if (SYNC_STAGES < 2) begin : g_bad_sync_cfg
        $error("i2c_pad_arbiter: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (2 ** TIMEOUT_W)) begin : g_bad_timeout_cfg
        $error("i2c_pad_arbiter: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   sda_hist_reg;
    logic                   scl_s;
    logic                   sda_s;
    logic                   start_det_reg;
    logic                   stop_det_reg;
    logic                   busy_reg;
    logic                   timeout_hit;
    logic [1:0]             state_reg;
    logic [1:0]             state_next;
    logic                   rr_reg;
    logic                   rr_next;
    logic                   bus_free;
    logic                   bus_active;

    // Bus sense: synchronizers reset high so a released bus never looks like an edge.
    always_ff @(posedge CLK_I) begin
        if (RESET) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], SCL_PAD_I};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], SDA_PAD_I};
            sda_hist_reg <= sda_s;
        end
    end

    assign scl_s = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s = sda_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge CLK_I) begin
        if (RESET) begin
            start_det_reg <= 1'b0;
            stop_det_reg  <= 1'b0;
        end else begin
            start_det_reg <= scl_s & sda_hist_reg & ~sda_s;
            stop_det_reg  <= scl_s & ~sda_hist_reg & sda_s;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic                 scl_hist_reg;
    logic [TIMEOUT_W-1:0] to_cnt_reg;
    logic                 timeout_reg;
    logic                 scl_edge;

    assign scl_edge    = scl_s ^ scl_hist_reg;
    assign timeout_hit = busy_reg & ~scl_edge & (to_cnt_reg == TIMEOUT_LAST);

    // Saturating idle-SCL counter; any SCL activity or a free bus restarts it.
    always_ff @(posedge CLK_I) begin
        if (RESET) begin
            scl_hist_reg <= 1'b1;
            to_cnt_reg   <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            scl_hist_reg <= scl_s;
            timeout_reg  <= timeout_hit;
            if (!busy_reg || scl_edge) begin
                to_cnt_reg <= '0;
            end else if (to_cnt_reg != '1) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
        end
    end

    assign TIMEOUT = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign TIMEOUT     = 1'b0;
`endif

    always_ff @(posedge CLK_I) begin
        if (RESET) begin
            busy_reg <= 1'b0;
        end else if (timeout_hit) begin
            busy_reg <= 1'b0;
        end else if (start_det_reg) begin
            busy_reg <= 1'b1;
        end else if (stop_det_reg) begin
            busy_reg <= 1'b0;
        end
    end

    // A START pulse already in flight counts as a busy bus for granting and releasing.
    assign bus_free   = ~busy_reg & ~start_det_reg;
    assign bus_active = busy_reg | start_det_reg;

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus_free && (REQ_A || REQ_B)) begin
                    if (REQ_A && (!REQ_B || rr_reg == RR_A)) begin
                        state_next = ST_OWN_A;
                        rr_next    = RR_B;
                    end else begin
                        state_next = ST_OWN_B;
                        rr_next    = RR_A;
                    end
                end
            end
            ST_OWN_A: begin
                if (!REQ_A) begin
                    state_next = bus_active ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_OWN_B: begin
                if (!REQ_B) begin
                    state_next = bus_active ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (stop_det_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            rr_reg    <= RR_A;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
        end
    end

    assign GNT_A     = (state_reg == ST_OWN_A);
    assign GNT_B     = (state_reg == ST_OWN_B);
    assign BUS_BUSY  = busy_reg;
    assign START_DET = start_det_reg;
    assign STOP_DET  = stop_det_reg;

    // Pads follow the registered owner, so reset releases them right after the edge.
    always_comb begin
        SCL_PAD_O    = 1'b0;
        SCL_PADOEN_O = 1'b1;
        SDA_PAD_O    = 1'b0;
        SDA_PADOEN_O = 1'b1;
        if (state_reg == ST_OWN_A) begin
            SCL_PAD_O    = A_SCL_PAD_O;
            SCL_PADOEN_O = A_SCL_PADOEN_O;
            SDA_PAD_O    = A_SDA_PAD_O;
            SDA_PADOEN_O = A_SDA_PADOEN_O;
        end else if (state_reg == ST_OWN_B) begin
            SCL_PAD_O    = B_SCL_PAD_O;
            SCL_PADOEN_O = B_SCL_PADOEN_O;
            SDA_PAD_O    = B_SDA_PAD_O;
            SDA_PADOEN_O = B_SDA_PADOEN_O;
        end
    end

endmodule

// File: tb/tb_i2c_pad_arbiter.sv
// Directed-vector bench for i2c_pad_arbiter: per-cycle stimulus/expectation table plus
// latency sequences; the stuck-bus sequence runs only with I2C_ARB_TIMEOUT_EN.
module tb_i2c_pad_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ra, rb;
    logic a_scl_low, a_sda_low, b_scl_low, b_sda_low, x_scl_low, x_sda_low;

    logic gnt_a, gnt_b, scl_o, scl_oen, sda_o, sda_oen;
    logic busy, start_det, stop_det, timeout;
    logic scl_bus, sda_bus;

    // Open-drain wired-AND with pull-up: arbiter pad output plus an external master.
    assign scl_bus = ~((~scl_oen & ~scl_o) | x_scl_low);
    assign sda_bus = ~((~sda_oen & ~sda_o) | x_sda_low);

    i2c_pad_arbiter #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (100),
        .TIMEOUT_W      (16)
    ) dut (
        .CLK_I          (clk),
        .RESET          (rst),
        .REQ_A          (ra),
        .REQ_B          (rb),
        .GNT_A          (gnt_a),
        .GNT_B          (gnt_b),
        .A_SCL_PAD_O    (~a_scl_low),
        .A_SCL_PADOEN_O (~a_scl_low),
        .A_SDA_PAD_O    (~a_sda_low),
        .A_SDA_PADOEN_O (~a_sda_low),
        .B_SCL_PAD_O    (~b_scl_low),
        .B_SCL_PADOEN_O (~b_scl_low),
        .B_SDA_PAD_O    (~b_sda_low),
        .B_SDA_PADOEN_O (~b_sda_low),
        .SCL_PAD_I      (scl_bus),
        .SDA_PAD_I      (sda_bus),
        .SCL_PAD_O      (scl_o),
        .SCL_PADOEN_O   (scl_oen),
        .SDA_PAD_O      (sda_o),
        .SDA_PADOEN_O   (sda_oen),
        .BUS_BUSY       (busy),
        .START_DET      (start_det),
        .STOP_DET       (stop_det),
        .TIMEOUT        (timeout)
    );

    // stim: rst ra rb a_scl a_sda b_scl b_sda x_scl x_sda (pad bits = drive low)
    // exp : gnt_a gnt_b busy start stop scl_oen sda_oen
    typedef struct packed {
        logic [8:0] stim;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic [8:0] stim, input logic [6:0] exp);
        vecs.push_back(vec_t'({stim, exp}));
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return gnt_a;
            1:       return start_det;
            2:       return stop_det;
            3:       return busy;
            4:       return timeout;
            default: return 1'b0;
        endcase
    endfunction

    // Returns the number of edges until the probed output is seen, or -1 if the budget expires.
    task automatic cycles_until(input int sel, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (probe(sel)) return;
        end
        n = -1;
    endtask

    initial begin
        logic [6:0] act;
        logic       owner;
        int         n;

        {rst, ra, rb, a_scl_low, a_sda_low, b_scl_low, b_sda_low, x_scl_low, x_sda_low} = '0;

        add(9'b1_00_00_00_00, 7'b00_000_11); // reset
        // A alone: grant, START, SCL low/high, STOP
        add(9'b0_10_00_00_00, 7'b10_000_11);
        add(9'b0_10_01_00_00, 7'b10_000_10);
        add(9'b0_10_01_00_00, 7'b10_000_10);
        add(9'b0_10_01_00_00, 7'b10_010_10);
        add(9'b0_10_11_00_00, 7'b10_100_00);
        add(9'b0_10_01_00_00, 7'b10_100_10);
        add(9'b0_10_00_00_00, 7'b10_100_11);
        add(9'b0_10_00_00_00, 7'b10_100_11);
        add(9'b0_10_00_00_00, 7'b10_101_11);
        add(9'b0_10_00_00_00, 7'b10_000_11);
        add(9'b0_00_00_00_00, 7'b00_000_11);
        // simultaneous requests after reset, round robin
        add(9'b1_00_00_00_00, 7'b00_000_11);
        add(9'b0_11_00_00_00, 7'b10_000_11);
        add(9'b0_01_00_00_00, 7'b00_000_11);
        add(9'b0_01_00_00_00, 7'b01_000_11);
        add(9'b0_10_00_00_00, 7'b00_000_11);
        add(9'b0_11_00_00_00, 7'b10_000_11);
        add(9'b0_01_00_00_00, 7'b00_000_11);
        add(9'b0_01_00_00_00, 7'b01_000_11);
        // B starts, drops REQ mid-transfer -> DRAIN while external holds SDA
        add(9'b0_11_00_01_00, 7'b01_000_10);
        add(9'b0_11_00_01_00, 7'b01_000_10);
        add(9'b0_11_00_01_00, 7'b01_010_10);
        add(9'b0_11_00_01_00, 7'b01_100_10);
        add(9'b0_10_00_01_01, 7'b00_100_11);
        add(9'b0_10_00_01_01, 7'b00_100_11);
        add(9'b0_10_00_01_01, 7'b00_100_11);
        add(9'b0_10_00_00_00, 7'b00_100_11);
        add(9'b0_10_00_00_00, 7'b00_100_11);
        add(9'b0_10_00_00_00, 7'b00_101_11);
        add(9'b0_10_00_00_00, 7'b00_000_11);
        add(9'b0_10_00_00_00, 7'b10_000_11);
        // foreign START while idle; REQ_B raised in the START_DET cycle
        add(9'b0_00_00_00_00, 7'b00_000_11);
        add(9'b0_00_00_00_01, 7'b00_000_11);
        add(9'b0_00_00_00_01, 7'b00_000_11);
        add(9'b0_00_00_00_01, 7'b00_010_11);
        add(9'b0_01_00_00_01, 7'b00_100_11);
        add(9'b0_01_00_00_01, 7'b00_100_11);
        add(9'b0_01_00_00_00, 7'b00_100_11);
        add(9'b0_01_00_00_00, 7'b00_100_11);
        add(9'b0_01_00_00_00, 7'b00_101_11);
        add(9'b0_01_00_00_00, 7'b00_000_11);
        add(9'b0_01_00_00_00, 7'b01_000_11);
        // reset while B owns a busy bus with SCL held low
        add(9'b0_01_00_01_00, 7'b01_000_10);
        add(9'b0_01_00_01_00, 7'b01_000_10);
        add(9'b0_01_00_01_00, 7'b01_010_10);
        add(9'b0_01_00_11_00, 7'b01_100_00);
        add(9'b1_01_00_11_00, 7'b00_000_11);
        add(9'b0_00_00_00_00, 7'b00_000_11);

        for (int i = 0; i < vecs.size(); i++) begin
            {rst, ra, rb, a_scl_low, a_sda_low, b_scl_low, b_sda_low, x_scl_low, x_sda_low} = vecs[i].stim;
            @(posedge clk);
            #1;
            act   = {gnt_a, gnt_b, busy, start_det, stop_det, scl_oen, sda_oen};
            owner = vecs[i].exp[6] | vecs[i].exp[5];
            $display("vec%0d stim=%b out=%b pads=%b%b to=%b", i, vecs[i].stim, act, scl_o, sda_o, timeout);
            check($sformatf("vec%0d", i), int'({act, scl_o, sda_o, timeout}),
                  int'({vecs[i].exp, owner & vecs[i].exp[1], owner & vecs[i].exp[0], 1'b0}));
        end

        // Grant and pad-edge-to-pulse latency measured from the driving side.
        ra = 1'b1;
        cycles_until(0, 8, n);
        $display("seq grant latency=%0d", n);
        check("grant_latency", n, 1);
        a_sda_low = 1'b1;
        cycles_until(1, 10, n);
        $display("seq start latency=%0d", n);
        check("start_latency", n, 3);
        a_sda_low = 1'b0;
        cycles_until(2, 10, n);
        $display("seq stop latency=%0d", n);
        check("stop_latency", n, 3);
        @(posedge clk);
        #1;
        $display("seq busy after stop=%b", busy);
        check("busy_clear", int'(busy), 0);
        ra = 1'b0;
        repeat (2) @(posedge clk);
        #1;

`ifdef I2C_ARB_TIMEOUT_EN
        ra = 1'b1;
        cycles_until(0, 8, n);
        check("to_grant", n, 1);
        a_sda_low = 1'b1;
        cycles_until(3, 10, n);
        check("to_busy_latency", n, 4);
        cycles_until(4, 200, n);
        $display("seq timeout after=%0d busy=%b gnt_a=%b", n, busy, gnt_a);
        check("timeout_cycles", n, 100);
        check("timeout_busy", int'(busy), 0);
        check("timeout_gnt", int'(gnt_a), 0);
        ra        = 1'b0;
        a_sda_low = 1'b0;
        @(posedge clk);
        #1;
        check("timeout_pulse_width", int'(timeout), 0);
        repeat (5) @(posedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
